// File: rtl/fp_mul_seq_arb_if.sv
// ----------------------------------------------------------------------------
// fp_mul_seq_arb_if
// Bundles the two requester channels and the response channel of the
// shared binary32 multiplier front end.
//
// Handshake rule (applies to every channel): a transfer happens on a rising
// clock edge where valid and ready are both high. The producer keeps valid
// and its payload stable until that edge. reqN_ready is combinational and
// may only be high in the idle state. rsp_valid stays high, with stable
// payload, until the edge where rsp_ready is also high.
//
// Signals:
//   req0_valid/req0_ready/req0_a/req0_b   requester 0 operand pair
//   req1_valid/req1_ready/req1_a/req1_b   requester 1 operand pair
//   rsp_valid/rsp_ready                   result handshake
//   rsp_id                                requester that owns the result
//   rsp_out                               binary32 product (0 when flagged)
//   rsp_overflow/rsp_underflow            exponent range flags
// Modports: master = requesters + consumer, slave = multiplier.
// ----------------------------------------------------------------------------
interface fp_mul_seq_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_out;
  logic        rsp_overflow;
  logic        rsp_underflow;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_overflow, rsp_underflow
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_overflow, rsp_underflow
  );
endinterface

// File: rtl/fp_mul_seq_arb.sv
// ----------------------------------------------------------------------------
// fp_mul_seq_arb
// Two-requester round-robin front end and sequencer for a binary32
// multiplier. The mantissa product is built by a shift-add loop that runs
// one iteration per clock (N_ITER iterations), then normalised, packed,
// range-flagged (truncation, no rounding) and returned with the id of the
// requester that won arbitration.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   bus        fp_mul_seq_arb_if.slave (request and response channels)
//   busy       high whenever the FSM is not in IDLE
//   dbg_state  current FSM state (0 IDLE, 1 ITER, 2 NORM, 3 DONE)
//
// Optional feature macro: FP_MUL_ZERO_EN
//   When defined, an operand with exponent field 0 bypasses the iteration
//   loop and the result is a signed zero with both flags clear. When
//   undefined, such operands take the full path like any other value.
// ----------------------------------------------------------------------------
module fp_mul_seq_arb #(
  parameter int N_ITER   = 24,
  parameter int EXP_BIAS = 127
) (
  input  logic               clk,
  input  logic               rst,
  fp_mul_seq_arb_if.slave    bus,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic        rr_q;          // 0: requester 0 wins a tie, 1: requester 1
  logic        id_q;
  logic        sign_q;
  logic [8:0]  ea_q;
  logic [8:0]  eb_q;
  logic [23:0] a_man_q;       // A mantissa with hidden 1
  logic [48:0] acc_q;         // upper half: partial product, lower: B mantissa
  logic [4:0]  cnt_q;
  logic        zero_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_out_q;
  logic        rsp_ovf_q;
  logic        rsp_unf_q;

  // Arbitration
  logic        grant0;
  logic        grant1;
  logic [31:0] a_sel;
  logic [31:0] b_sel;
  logic        zero_op;

  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  rr_q);
  assign a_sel  = grant1 ? bus.req1_a : bus.req0_a;
  assign b_sel  = grant1 ? bus.req1_b : bus.req0_b;

  assign bus.req0_ready = (state_q == IDLE) & grant0;
  assign bus.req1_ready = (state_q == IDLE) & grant1;

`ifdef FP_MUL_ZERO_EN
  assign zero_op = (a_sel[30:23] == 8'd0) | (b_sel[30:23] == 8'd0);
`else
  assign zero_op = 1'b0;
`endif

  // One shift-add step. The partial product never exceeds 25 bits, so the
  // sum fits in the 49-bit accumulator without a carry out.
  logic [48:0] a_shift;
  logic [48:0] acc_sum;
  logic [48:0] acc_d;

  assign a_shift = {1'b0, a_man_q, 24'd0};
  assign acc_sum = acc_q + a_shift;
  assign acc_d   = acc_q[0] ? (acc_sum >> 1) : (acc_q >> 1);

  // Normalise and pack. ex is kept in 9 bits so that wrap-around below
  // zero shows up as ex[8:7] == 2'b11 and overflow as 2'b10 or 255.
  logic [47:0] prod;
  logic [8:0]  ex_raw;
  logic [8:0]  ex_d;
  logic [22:0] frac_d;
  logic        ovf_d;
  logic        unf_d;

  assign prod   = acc_q[47:0];
  assign ex_raw = ea_q + eb_q - 9'(EXP_BIAS);
  assign ex_d   = prod[47] ? ex_raw + 9'd1 : ex_raw;
  assign frac_d = prod[47] ? prod[46:24] : prod[45:23];
  assign ovf_d  = (ex_d == 9'd255) | (ex_d[8:7] == 2'b10);
  assign unf_d  = ~ovf_d & (ex_d[8:7] == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      a_man_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 | grant1) begin
            rr_q    <= grant0;
            id_q    <= grant1;
            sign_q  <= a_sel[31] ^ b_sel[31];
            ea_q    <= {1'b0, a_sel[30:23]};
            eb_q    <= {1'b0, b_sel[30:23]};
            a_man_q <= {1'b1, a_sel[22:0]};
            acc_q   <= {25'd0, 1'b1, b_sel[22:0]};
            cnt_q   <= 5'(N_ITER);
            zero_q  <= zero_op;
            state_q <= zero_op ? NORM : ITER;
          end
        end
        ITER: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= NORM;
        end
        NORM: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          if (zero_q) begin
            rsp_out_q <= {sign_q, 31'd0};
            rsp_ovf_q <= 1'b0;
            rsp_unf_q <= 1'b0;
          end else begin
            rsp_out_q <= (ovf_d | unf_d) ? 32'd0 : {sign_q, ex_d[7:0], frac_d};
            rsp_ovf_q <= ovf_d;
            rsp_unf_q <= unf_d;
          end
          state_q <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_out       = rsp_out_q;
  assign bus.rsp_overflow  = rsp_ovf_q;
  assign bus.rsp_underflow = rsp_unf_q;
  assign busy              = (state_q != IDLE);
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_fp_mul_seq_arb.sv
// ----------------------------------------------------------------------------
// tb_fp_mul_seq_arb
// Directed bench for fp_mul_seq_arb. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_fp_mul_seq_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  fp_mul_seq_arb_if bus ();

  fp_mul_seq_arb dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The two ready lines must never be high together.
  always @(negedge clk) begin
    if (!rst && (bus.req0_ready || bus.req1_ready))
      check("ready_exclusive", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
  end

  // Drivers
  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  // Presents one operand pair on a single requester, checks it is granted
  // immediately, and returns at the falling edge after the accept edge.
  task automatic issue(input bit which, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (which == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end
    #1;
    check("issue_ready", {31'd0, which ? bus.req1_ready : bus.req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Starts at the falling edge after the accept edge; counts rising edges
  // until rsp_valid is seen and checks the response payload.
  task automatic wait_rsp(input bit exp_id, input logic [31:0] exp_out,
                          input bit exp_ovf, input bit exp_unf, input int exp_lat);
    int edges = 0;
    while (bus.rsp_valid !== 1'b1 && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("latency", edges, exp_lat);
    check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, exp_id});
    check("rsp_out", bus.rsp_out, exp_out);
    check("rsp_overflow", {31'd0, bus.rsp_overflow}, {31'd0, exp_ovf});
    check("rsp_underflow", {31'd0, bus.rsp_underflow}, {31'd0, exp_unf});
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("idle_after_rsp", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt0;
    int cnt1;
    int n;
    idle_inputs();
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_out", bus.rsp_out, 32'd0);

    // 2.0 x 3.0 = 6.0 from requester 0
    issue(1'b0, 32'h40000000, 32'h40400000);
    check("busy_in_iter", {31'd0, busy}, 32'd1);
    wait_rsp(1'b0, 32'h40C00000, 1'b0, 1'b0, 25);
    release_rsp();

    // 1.5 x 1.5 = 2.25 from requester 1, then negative A
    issue(1'b1, 32'h3FC00000, 32'h3FC00000);
    wait_rsp(1'b1, 32'h40100000, 1'b0, 1'b0, 25);
    release_rsp();
    issue(1'b1, 32'hBFC00000, 32'h3FC00000);
    wait_rsp(1'b1, 32'hC0100000, 1'b0, 1'b0, 25);
    release_rsp();

    // Exponent range: 2^127 x 2^127 overflows, 2^-126 x 2^-126 underflows
    issue(1'b0, 32'h7F000000, 32'h7F000000);
    wait_rsp(1'b0, 32'h00000000, 1'b1, 1'b0, 25);
    release_rsp();
    issue(1'b0, 32'h00800000, 32'h00800000);
    wait_rsp(1'b0, 32'h00000000, 1'b0, 1'b1, 25);
    release_rsp();

    // Both requesters held valid from reset: grants alternate 0,1,0,1
    do_reset();
    @(negedge clk);
    cnt0 = 0;
    cnt1 = 0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h40000000; bus.req0_b = 32'h40400000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h3FC00000; bus.req1_b = 32'h3FC00000;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      #1;
      while (!(bus.req0_ready || bus.req1_ready) && n < 60) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rr_grant_seen", {31'd0, bus.req0_ready | bus.req1_ready}, 32'd1);
      check("rr_grant_id", {31'd0, bus.req1_ready}, (j % 2));
      if (bus.req0_ready) cnt0++;
      if (bus.req1_ready) cnt1++;
      @(posedge clk);
      @(negedge clk);
      wait_rsp(j[0], j[0] ? 32'h40100000 : 32'h40C00000, 1'b0, 1'b0, 25);
      release_rsp();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr_count0", cnt0, 32'd2);
    check("rr_count1", cnt1, 32'd2);

    // Response stall: outputs stay put, no new grant while waiting
    do_reset();
    issue(1'b0, 32'h40000000, 32'h40400000);
    wait_rsp(1'b0, 32'h40C00000, 1'b0, 1'b0, 25);
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h3FC00000;
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_out", bus.rsp_out, 32'h40C00000);
      check("stall_ready0", {31'd0, bus.req0_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("stall_next_ready", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("stall_next_busy", {31'd0, busy}, 32'd1);
    wait_rsp(1'b0, 32'h40100000, 1'b0, 1'b0, 25);
    release_rsp();

    // Reset in the middle of the loop (12 iterations left)
    issue(1'b0, 32'h40000000, 32'h40400000);
    repeat (12) @(negedge clk);
    check("mid_state_iter", {30'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort_rsp_out", bus.rsp_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h3FC00000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h40000000; bus.req1_b = 32'h40400000;
    #1;
    check("post_reset_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("post_reset_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(1'b0, 32'h40100000, 1'b0, 1'b0, 25);
    release_rsp();

    // Zero-exponent operand: 0 x -2
`ifdef FP_MUL_ZERO_EN
    issue(1'b0, 32'h00000000, 32'hC0000000);
    wait_rsp(1'b0, 32'h80000000, 1'b0, 1'b0, 1);
    release_rsp();
`else
    // Hidden 1 inserted: 2^-127 x -2 -> -2^-126 (ex = 1)
    issue(1'b0, 32'h00000000, 32'hC0000000);
    wait_rsp(1'b0, 32'h80800000, 1'b0, 1'b0, 25);
    release_rsp();
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
